// File: rtl/fetch_pkg.sv
// Shared types and constants for the SimpRisc fetch stage.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] INSTR_BYTES = 32'd4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory, redirect and decode handshake signals of the fetch stage.
interface fetch_if;

  logic [31:0] pc;
  logic [31:0] instruction;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;

  modport master (
    output pc,
    input  instruction,
    input  redirect_valid,
    input  redirect_pc,
    output dec_valid,
    input  dec_ready,
    output dec_instr,
    output dec_pc
  );

  modport slave (
    input  pc,
    output instruction,
    output redirect_valid,
    output redirect_pc,
    input  dec_valid,
    output dec_ready,
    input  dec_instr,
    input  dec_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small instruction FIFO holding {pc, instr} pairs; flush empties it in one edge.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_entry,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  fetch_entry_t mem [DEPTH];
  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PtrOne;
      if (pop)  rd_q <= rd_q + PtrOne;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_q[AW-1:0]] <= push_entry;
  end

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head  = empty ? '{pc: 32'h0, instr: NOP_INSTR} : mem[rd_q[AW-1:0]];

endmodule

// File: rtl/fetch_unit.sv
// SimpRisc fetch stage: PC register, imem request, instruction FIFO and redirect flush.
// Optional FETCH_PERF_EN adds fetch_count / stall_count performance counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  fetch_if.master     bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  logic [31:0]  pc_q;
  logic [31:0]  pc_d;
  logic         push;
  logic         pop;
  logic         full;
  logic         empty;
  fetch_entry_t push_entry;
  fetch_entry_t head;

  assign pop        = bus.dec_valid && bus.dec_ready;
  assign push       = !bus.redirect_valid && (!full || pop);
  assign push_entry = '{pc: pc_q, instr: bus.instruction};

  always_comb begin
    pc_d = pc_q;
    if (bus.redirect_valid) begin
      pc_d = {bus.redirect_pc[31:2], 2'b00};
    end else if (push) begin
      pc_d = pc_q + INSTR_BYTES;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  // A popped head is still handed to decode even when the same edge flushes.
  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (bus.redirect_valid),
    .push_entry(push_entry),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

  assign bus.pc        = pc_q;
  assign bus.dec_valid = !empty;
  assign bus.dec_instr = head.instr;
  assign bus.dec_pc    = head.pc;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (push) fetch_count <= fetch_count + 32'd1;
      if (bus.dec_valid && !bus.dec_ready) stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (RESET_PC = 0x100, FIFO_DEPTH = 2).
module tb_fetch_unit;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  fetch_if bus ();

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  fetch_unit #(
    .RESET_PC  (32'h0000_0100),
    .FIFO_DEPTH(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count(fetch_count),
    .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory contents as a function of address.
  function automatic logic [31:0] f(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign bus.instruction = f(bus.pc);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_from_zero();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0;
    bus.dec_ready      = 1'b0;
    step();
    bus.redirect_valid = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.dec_ready      = 1'b0;
    step();
    step();
    checks++;
    if (bus.pc !== 32'h100) begin
      errors++; $display("FAIL reset_pc got %h want %h", bus.pc, 32'h100);
    end
    checks++;
    if (bus.dec_valid !== 1'b0) begin
      errors++; $display("FAIL reset_dec_valid got %b want 0", bus.dec_valid);
    end
    checks++;
    if (bus.dec_instr !== 32'h0 || bus.dec_pc !== 32'h0) begin
      errors++; $display("FAIL reset_dec_data got %h/%h want 0/0", bus.dec_instr, bus.dec_pc);
    end
`ifdef FETCH_PERF_EN
    checks++;
    if (fetch_count !== 32'h0 || stall_count !== 32'h0) begin
      errors++; $display("FAIL reset_counters got %0d/%0d want 0/0", fetch_count, stall_count);
    end
`endif
  endtask

  task automatic test_free_run();
    logic [31:0] exp;
    reset = 1'b0;
    bus.dec_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      exp = 32'h100 + 32'(4 * i);
      checks++;
      if (bus.dec_valid !== 1'b1 || bus.dec_pc !== exp || bus.dec_instr !== f(exp)) begin
        errors++;
        $display("FAIL free_run[%0d] got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                 i, bus.dec_valid, bus.dec_pc, bus.dec_instr, exp, f(exp));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] prev;
    int          pushes;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0;
    bus.dec_ready      = 1'b1;
    step();
    bus.redirect_valid = 1'b0;
    bus.dec_ready      = 1'b0;
    prev   = bus.pc;
    pushes = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.pc !== prev) pushes++;
      prev = bus.pc;
    end
    checks++;
    if (pushes != 2) begin
      errors++; $display("FAIL bp_pushes got %0d want 2", pushes);
    end
    checks++;
    if (bus.pc !== 32'h8) begin
      errors++; $display("FAIL bp_pc_frozen got %h want %h", bus.pc, 32'h8);
    end
    checks++;
    if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 32'h0) begin
      errors++; $display("FAIL bp_head_held got v=%b pc=%h want v=1 pc=0", bus.dec_valid,
                         bus.dec_pc);
    end
    bus.dec_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 32'(4 * i)) begin
        errors++; $display("FAIL bp_resume[%0d] got v=%b pc=%h want v=1 pc=%h", i,
                           bus.dec_valid, bus.dec_pc, 32'(4 * i));
      end
    end
  endtask

  task automatic test_redirect_stall();
    fill_from_zero();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h2003;
    step();
    checks++;
    if (bus.dec_valid !== 1'b0 || bus.pc !== 32'h2000) begin
      errors++; $display("FAIL redir_stall_n1 got v=%b pc=%h want v=0 pc=%h", bus.dec_valid,
                         bus.pc, 32'h2000);
    end
    bus.redirect_valid = 1'b0;
    bus.dec_ready      = 1'b1;
    step();
    checks++;
    if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 32'h2000 || bus.dec_instr !== f(32'h2000)) begin
      errors++; $display("FAIL redir_stall_n2 got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                         bus.dec_valid, bus.dec_pc, bus.dec_instr, 32'h2000, f(32'h2000));
    end
  endtask

  task automatic test_redirect_pop();
    logic [31:0] exp;
    fill_from_zero();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h3000;
    bus.dec_ready      = 1'b1;
    checks++;
    if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 32'h0) begin
      errors++; $display("FAIL redir_pop_head got v=%b pc=%h want v=1 pc=0", bus.dec_valid,
                         bus.dec_pc);
    end
    step();
    checks++;
    if (bus.dec_valid !== 1'b0 || bus.pc !== 32'h3000) begin
      errors++; $display("FAIL redir_pop_flush got v=%b pc=%h want v=0 pc=%h", bus.dec_valid,
                         bus.pc, 32'h3000);
    end
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      exp = 32'h3000 + 32'(4 * i);
      checks++;
      if (bus.dec_valid !== 1'b1 || bus.dec_pc !== exp) begin
        errors++; $display("FAIL redir_pop_seq[%0d] got v=%b pc=%h want v=1 pc=%h", i,
                           bus.dec_valid, bus.dec_pc, exp);
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp [3];
    exp[0] = 32'hFFFF_FFF8;
    exp[1] = 32'hFFFF_FFFC;
    exp[2] = 32'h0000_0000;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFF8;
    bus.dec_ready      = 1'b1;
    step();
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.dec_valid !== 1'b1 || bus.dec_pc !== exp[i] || bus.dec_instr !== f(exp[i])) begin
        errors++; $display("FAIL wrap[%0d] got v=%b pc=%h want v=1 pc=%h", i, bus.dec_valid,
                           bus.dec_pc, exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    reset              = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h4000;
    bus.dec_ready      = 1'b1;
    step();
    checks++;
    if (bus.pc !== 32'h100 || bus.dec_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid got pc=%h v=%b want pc=%h v=0", bus.pc, bus.dec_valid,
                         32'h100);
    end
`ifdef FETCH_PERF_EN
    checks++;
    if (fetch_count !== 32'h0 || stall_count !== 32'h0) begin
      errors++; $display("FAIL reset_mid_counters got %0d/%0d want 0/0", fetch_count,
                         stall_count);
    end
`endif
    reset              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.dec_ready      = 1'b0;
    step();
    checks++;
    if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 32'h100) begin
      errors++; $display("FAIL reset_mid_resume got v=%b pc=%h want v=1 pc=%h", bus.dec_valid,
                         bus.dec_pc, 32'h100);
    end
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (bus.pc !== 32'h108 || bus.dec_pc !== 32'h100) begin
      errors++; $display("FAIL reset_mid_stall got pc=%h dec_pc=%h want pc=%h dec_pc=%h",
                         bus.pc, bus.dec_pc, 32'h108, 32'h100);
    end
`ifdef FETCH_PERF_EN
    checks++;
    if (stall_count !== 32'd3 || fetch_count !== 32'd2) begin
      errors++; $display("FAIL perf_counters got stall=%0d fetch=%0d want stall=3 fetch=2",
                         stall_count, fetch_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_backpressure();
    test_redirect_stall();
    test_redirect_pop();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
